// File: rtl/dlatch_wr_sched_if.sv
// Requester-side and latch-bank-side signals of the latch write scheduler.
interface dlatch_wr_sched_if #(
  parameter int NREQ  = 4,
  parameter int W     = 8,
  parameter int NWORD = 4,
  parameter int AW    = 2
) ();
  localparam int IW = $clog2(NREQ);

  logic [NREQ-1:0]    req;
  logic [NREQ*AW-1:0] addr;
  logic [NREQ*W-1:0]  data;
  logic [NREQ-1:0]    ack;
  logic               err;
  logic [NWORD-1:0]   lat_en;
  logic [W-1:0]       lat_d;
  logic               busy;
  logic [IW-1:0]      gnt_id;

  // requester side drives requests and observes scheduler outputs
  modport master (
    output req, addr, data,
    input  ack, err, lat_en, lat_d, busy, gnt_id
  );

  // scheduler side
  modport slave (
    input  req, addr, data,
    output ack, err, lat_en, lat_d, busy, gnt_id
  );
endinterface

// File: rtl/dlatch_wr_sched.sv
// Round-robin write scheduler for a bank of level-sensitive latch words.
// Each write runs SETUP -> OPEN (OPEN_CYC cycles) -> HOLD -> ACK so the
// latch enable is only high while lat_d is stable.
module dlatch_wr_sched #(
  parameter int NREQ     = 4,
  parameter int W        = 8,
  parameter int NWORD    = 4,
  parameter int AW       = 2,
  parameter int OPEN_CYC = 1
) (
  input  logic             clk,
  input  logic             rst,
  dlatch_wr_sched_if.slave bus
);
  localparam int IW = $clog2(NREQ);
  localparam int CW = 4;

  typedef enum logic [2:0] {IDLE, SETUP, OPEN, HOLD, ACK} state_t;

  state_t           state;
  logic [IW-1:0]    ptr;
  logic [AW-1:0]    cap_addr;
  logic [CW-1:0]    cnt;

  logic             found;
  logic [IW-1:0]    cand;
  logic [IW-1:0]    pick;
  logic [AW-1:0]    pick_addr;
  logic [W-1:0]     pick_data;
  logic [NWORD-1:0] en_mask;
  logic             addr_ok;

  // first requesting index at or after ptr+1, wrapping
  always_comb begin
    found = 1'b0;
    pick  = '0;
    cand  = '0;
    for (int unsigned i = 1; i <= NREQ; i++) begin
      cand = IW'((32'(ptr) + i) % NREQ);
      if (!found && bus.req[cand]) begin
        found = 1'b1;
        pick  = cand;
      end
    end
  end

  // address/data slice of the selected requester
  always_comb begin
    pick_addr = '0;
    pick_data = '0;
    for (int unsigned j = 0; j < NREQ; j++) begin
      if (pick == IW'(j)) begin
        pick_addr = bus.addr[j*AW +: AW];
        pick_data = bus.data[j*W +: W];
      end
    end
  end

  // one-hot enable for the captured word; all-zero when out of range
  always_comb begin
    en_mask = '0;
    for (int unsigned w = 0; w < NWORD; w++) begin
      if (cap_addr == AW'(w)) en_mask[w] = 1'b1;
    end
  end

  assign addr_ok = |en_mask;

  // write sequencing FSM with registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      ptr        <= IW'(NREQ - 1);
      cap_addr   <= '0;
      cnt        <= '0;
      bus.ack    <= '0;
      bus.err    <= 1'b0;
      bus.lat_en <= '0;
      bus.lat_d  <= '0;
      bus.busy   <= 1'b0;
      bus.gnt_id <= '0;
    end else begin
      case (state)
        IDLE: begin
          bus.ack <= '0;
          bus.err <= 1'b0;
          if (found) begin
            // lat_d is loaded here so it is stable for the whole write
            cap_addr   <= pick_addr;
            bus.lat_d  <= pick_data;
            bus.gnt_id <= pick;
            bus.busy   <= 1'b1;
            state      <= SETUP;
          end
        end
        SETUP: begin
          bus.lat_en <= en_mask;
          cnt        <= CW'(OPEN_CYC - 1);
          state      <= OPEN;
        end
        OPEN: begin
          if (cnt == '0) begin
            bus.lat_en <= '0;
            state      <= HOLD;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        HOLD: begin
          bus.ack <= NREQ'(1) << bus.gnt_id;
          bus.err <= !addr_ok;
          state   <= ACK;
        end
        ACK: begin
          bus.ack  <= '0;
          bus.err  <= 1'b0;
          bus.busy <= 1'b0;
          ptr      <= bus.gnt_id;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_dlatch_wr_sched.sv
// Directed bench for dlatch_wr_sched: one default instance (OPEN_CYC=1)
// and one with a 3-bit address and OPEN_CYC=3 for out-of-range writes.
module tb_dlatch_wr_sched;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   ncmp = 0;
  int   nfail = 0;
  int   cyc = 0;
  logic mon_on = 1'b0;
  logic [3:0] prev_en = '0;
  logic [7:0] prev_d = '0;

  dlatch_wr_sched_if #(.NREQ(4), .W(8), .NWORD(4), .AW(2)) if_a ();
  dlatch_wr_sched_if #(.NREQ(4), .W(8), .NWORD(4), .AW(3)) if_b ();

  dlatch_wr_sched #(.NREQ(4), .W(8), .NWORD(4), .AW(2), .OPEN_CYC(1)) u_a (
    .clk(clk), .rst(rst), .bus(if_a)
  );
  dlatch_wr_sched #(.NREQ(4), .W(8), .NWORD(4), .AW(3), .OPEN_CYC(3)) u_b (
    .clk(clk), .rst(rst), .bus(if_b)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic wait_ack(input int maxc, output int at);
    logic seen;
    int   n;
    seen = 1'b0;
    n = 0;
    while (!seen && n < maxc) begin
      tick();
      n++;
      if (if_a.ack != '0) seen = 1'b1;
    end
    at = cyc;
    chk("ack_wait", 32'(seen), 32'd1);
  endtask

  // lat_d must not move while an enable is high or in the cycle after
  always @(negedge clk) begin
    if (mon_on && (if_a.lat_en != '0 || prev_en != '0))
      chk("lat_d_stable", 32'(if_a.lat_d), 32'(prev_d));
    prev_en = if_a.lat_en;
    prev_d  = if_a.lat_d;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    int tprev;
    int exp3 [4] = '{0, 3, 0, 3};
    if_a.req = '0; if_a.addr = '0; if_a.data = '0;
    if_b.req = '0; if_b.addr = '0; if_b.data = '0;
    t = 0;
    tprev = 0;

    // reset state
    tick();
    chk("rst_lat_en", 32'(if_a.lat_en), 32'h0);
    chk("rst_ack",    32'(if_a.ack),    32'h0);
    chk("rst_err",    32'(if_a.err),    32'h0);
    chk("rst_busy",   32'(if_a.busy),   32'h0);
    chk("rst_lat_d",  32'(if_a.lat_d),  32'h0);
    chk("rst_gnt",    32'(if_a.gnt_id), 32'h0);
    chk("rst_busy_b", 32'(if_b.busy),   32'h0);
    rst = 1'b0;
    tick();
    mon_on = 1'b1;

    // 1: single write, requester 2, addr 3, data A5
    if_a.addr[4 +: 2] = 2'd3;
    if_a.data[16 +: 8] = 8'hA5;
    if_a.req = 4'b0100;
    tick();
    chk("t1_busy",     32'(if_a.busy),   32'h1);
    chk("t1_gnt",      32'(if_a.gnt_id), 32'h2);
    chk("t1_d_setup",  32'(if_a.lat_d),  32'hA5);
    chk("t1_en_setup", 32'(if_a.lat_en), 32'h0);
    tick();
    chk("t1_en_open",  32'(if_a.lat_en), 32'h8);
    chk("t1_d_open",   32'(if_a.lat_d),  32'hA5);
    chk("t1_ack_open", 32'(if_a.ack),    32'h0);
    tick();
    chk("t1_en_hold",  32'(if_a.lat_en), 32'h0);
    chk("t1_d_hold",   32'(if_a.lat_d),  32'hA5);
    chk("t1_ack_hold", 32'(if_a.ack),    32'h0);
    tick();
    chk("t1_ack",      32'(if_a.ack),    32'h4);
    chk("t1_err",      32'(if_a.err),    32'h0);
    if_a.req = '0;
    tick();
    chk("t1_ack_off",  32'(if_a.ack),    32'h0);
    chk("t1_idle",     32'(if_a.busy),   32'h0);

    // 2: all four together after reset -> 0,1,2,3 spaced 5 cycles
    do_reset();
    for (int i = 0; i < 4; i++) begin
      if_a.addr[i*2 +: 2] = 2'(i);
      if_a.data[i*8 +: 8] = 8'h10 + 8'(i);
    end
    if_a.req = 4'b1111;
    for (int i = 0; i < 4; i++) begin
      wait_ack(20, t);
      chk("t2_ack",   32'(if_a.ack),    32'(1) << i);
      chk("t2_gnt",   32'(if_a.gnt_id), 32'(i));
      chk("t2_lat_d", 32'(if_a.lat_d),  32'h10 + 32'(i));
      if (i > 0) chk("t2_gap", 32'(t - tprev), 32'd5);
      tprev = t;
      if_a.req[i] = 1'b0;
    end
    tick();
    tick();

    // 3: requesters 0 and 3 held continuously alternate
    do_reset();
    if_a.addr[0 +: 2] = 2'd1; if_a.data[0 +: 8]  = 8'h33;
    if_a.addr[6 +: 2] = 2'd2; if_a.data[24 +: 8] = 8'hC3;
    if_a.req = 4'b1001;
    for (int i = 0; i < 4; i++) begin
      wait_ack(20, t);
      chk("t3_gnt", 32'(if_a.gnt_id), 32'(exp3[i]));
      chk("t3_ack", 32'(if_a.ack),    32'(1) << exp3[i]);
    end
    if_a.req = '0;
    tick();
    tick();

    // 4: OPEN_CYC=3, addr 5 out of range -> no enable, ack+err in cycle 6
    if_b.addr[0 +: 3] = 3'd5;
    if_b.data[0 +: 8] = 8'h5A;
    if_b.req = 4'b0001;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("t4_en_zero", 32'(if_b.lat_en), 32'h0);
      chk("t4_no_ack",  32'(if_b.ack),    32'h0);
    end
    tick();
    chk("t4_ack",    32'(if_b.ack),    32'h1);
    chk("t4_err",    32'(if_b.err),    32'h1);
    chk("t4_en",     32'(if_b.lat_en), 32'h0);
    if_b.req = '0;
    tick();
    chk("t4_ack_off", 32'(if_b.ack), 32'h0);
    chk("t4_err_off", 32'(if_b.err), 32'h0);

    // 5: async reset between edges during OPEN
    if_a.addr[4 +: 2] = 2'd1;
    if_a.data[16 +: 8] = 8'h77;
    if_a.req = 4'b0100;
    tick();
    tick();
    chk("t5_en_open", 32'(if_a.lat_en), 32'h2);
    #2;
    mon_on = 1'b0;
    rst = 1'b1;
    #1;
    chk("t5_en_rst",   32'(if_a.lat_en), 32'h0);
    chk("t5_busy_rst", 32'(if_a.busy),   32'h0);
    chk("t5_ack_rst",  32'(if_a.ack),    32'h0);
    rst = 1'b0;
    if_a.addr[0 +: 2] = 2'd0;
    if_a.data[0 +: 8] = 8'h11;
    if_a.req = 4'b0101;
    wait_ack(20, t);
    chk("t5_first_ack", 32'(if_a.ack),    32'h1);
    chk("t5_first_gnt", 32'(if_a.gnt_id), 32'h0);
    if_a.req[0] = 1'b0;
    wait_ack(20, t);
    chk("t5_second_ack", 32'(if_a.ack),   32'h4);
    chk("t5_second_d",   32'(if_a.lat_d), 32'h77);
    if_a.req = '0;
    tick();
    tick();
    mon_on = 1'b1;

    // 6: req[1] dropped during SETUP, captured data still written
    if_a.addr[2 +: 2] = 2'd0;
    if_a.data[8 +: 8] = 8'h6C;
    if_a.req = 4'b0010;
    tick();
    chk("t6_gnt", 32'(if_a.gnt_id), 32'h1);
    if_a.req = '0;
    if_a.addr[2 +: 2] = 2'd3;
    if_a.data[8 +: 8] = 8'hFF;
    tick();
    chk("t6_en",   32'(if_a.lat_en), 32'h1);
    chk("t6_d",    32'(if_a.lat_d),  32'h6C);
    tick();
    chk("t6_hold", 32'(if_a.lat_en), 32'h0);
    tick();
    chk("t6_ack",  32'(if_a.ack),    32'h2);
    tick();
    chk("t6_ack_off", 32'(if_a.ack),  32'h0);
    chk("t6_idle",    32'(if_a.busy), 32'h0);
    tick();
    tick();
    chk("t6_no_reack", 32'(if_a.ack),  32'h0);
    chk("t6_still_d",  32'(if_a.lat_d), 32'h6C);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end
endmodule
